// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern transmitter: Gray-coded FSM states,
// the default pattern and the even-parity helper used by SEQ_GEN_PARITY_EN builds.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StShift  = 2'b01,
    StParity = 2'b11,
    StDone   = 2'b10
  } state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  // Even parity bit: set when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/seq_gen_shifter.sv
// Pattern shift register for sequence_generator: load, shift-left, reload from the
// latched pattern, MSB out, plus the even parity of the latched pattern.
module seq_gen_shifter
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_reload,
  input  logic [PAT_W-1:0] i_pattern,
  output logic             o_msb,
  output logic             o_parity
);

  logic [PAT_W-1:0] r_shift;
  logic [PAT_W-1:0] r_latch;

  // Load wins over reload/shift; reload and shift are mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_shift <= '0;
      r_latch <= '0;
    end else if (i_load) begin
      r_shift <= i_pattern;
      r_latch <= i_pattern;
    end else if (i_reload) begin
      r_shift <= r_latch;
    end else if (i_shift) begin
      r_shift <= {r_shift[PAT_W-2:0], 1'b0};
    end
  end

  assign o_msb    = r_shift[PAT_W-1];
  assign o_parity = even_parity(32'(r_latch));

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter, MSB first, with repeat count and tx_en pacing.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit after every repetition.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [CNT_W-1:0] i_repeat_cnt,
  input  logic             i_tx_en,
  output logic             o_seq_out,
  output logic             o_seq_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned    BCW      = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(PAT_W - 1);

  state_e           r_state;
  logic [BCW-1:0]   r_bit_cnt;
  logic [CNT_W-1:0] r_rep_cnt;

  logic w_load;
  logic w_adv;
  logic w_last;
  logic w_more;
  logic w_shift;
  logic w_reload;
  logic w_msb;
  logic w_parity;

  assign w_load  = (r_state == StIdle) && i_start_valid;
  assign w_adv   = (r_state == StShift) && i_tx_en;
  assign w_last  = (r_bit_cnt == '0);
  assign w_more  = (r_rep_cnt != '0);
  assign w_shift = w_adv && !w_last;
`ifdef SEQ_GEN_PARITY_EN
  assign w_reload = (r_state == StParity) && i_tx_en && w_more;
`else
  assign w_reload = w_adv && w_last && w_more;
`endif

  seq_gen_shifter #(
    .PAT_W (PAT_W)
  ) u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_reload  (w_reload),
    .i_pattern (i_pattern),
    .o_msb     (w_msb),
    .o_parity  (w_parity)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start_valid) begin
            r_state   <= StShift;
            r_bit_cnt <= LAST_IDX;
            r_rep_cnt <= i_repeat_cnt;
          end
        end
        StShift: begin
          if (i_tx_en) begin
            if (!w_last) begin
              r_bit_cnt <= r_bit_cnt - 1'b1;
            end else begin
`ifdef SEQ_GEN_PARITY_EN
              r_state <= StParity;
`else
              if (w_more) begin
                r_rep_cnt <= r_rep_cnt - 1'b1;
                r_bit_cnt <= LAST_IDX;
              end else begin
                r_state <= StDone;
              end
`endif
            end
          end
        end
`ifdef SEQ_GEN_PARITY_EN
        StParity: begin
          if (i_tx_en) begin
            if (w_more) begin
              r_rep_cnt <= r_rep_cnt - 1'b1;
              r_bit_cnt <= LAST_IDX;
              r_state   <= StShift;
            end else begin
              r_state <= StDone;
            end
          end
        end
`endif
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign o_start_ready = (r_state == StIdle);
  assign o_busy        = (r_state != StIdle);
  assign o_done        = (r_state == StDone);
`ifdef SEQ_GEN_PARITY_EN
  assign o_seq_valid = (r_state == StShift) || (r_state == StParity);
  assign o_seq_out   = (r_state == StShift)  ? w_msb    :
                       (r_state == StParity) ? w_parity : 1'b0;
`else
  logic w_unused_parity;
  assign w_unused_parity = w_parity;
  assign o_seq_valid     = (r_state == StShift);
  assign o_seq_out       = (r_state == StShift) && w_msb;
`endif

endmodule

// File: tb/tb_sequence_generator.sv
// Directed self-checking bench for sequence_generator; expectations follow the
// SEQ_GEN_PARITY_EN setting of the build.
module tb_sequence_generator;
  import seq_gen_pkg::*;

`ifdef SEQ_GEN_PARITY_EN
  localparam int L = 5;
  localparam logic [63:0] EXP_1011  = 64'b10111;
  localparam logic [63:0] EXP_LOOP  = 64'b101111011110111;
  localparam logic [63:0] EXP_1100  = 64'b11000;
`else
  localparam int L = 4;
  localparam logic [63:0] EXP_1011  = 64'b1011;
  localparam logic [63:0] EXP_LOOP  = 64'b101110111011;
  localparam logic [63:0] EXP_1100  = 64'b1100;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_start_valid = 1'b0;
  logic       i_tx_en = 1'b0;
  logic [3:0] i_pattern = '0;
  logic [3:0] i_repeat_cnt = '0;
  logic       o_start_ready, o_seq_out, o_seq_valid, o_busy, o_done;

  int tests_run = 0;
  int tests_failed = 0;

  logic        bits [0:255];
  logic        tr_out [0:255];
  logic        tr_valid [0:255];
  logic [63:0] obs;
  int          nbits, done_off, done_cnt, det_cnt;
  logic        ready_after;

  sequence_generator #(
    .PAT_W (4),
    .CNT_W (4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_start_valid (i_start_valid),
    .o_start_ready (o_start_ready),
    .i_pattern     (i_pattern),
    .i_repeat_cnt  (i_repeat_cnt),
    .i_tx_en       (i_tx_en),
    .o_seq_out     (o_seq_out),
    .o_seq_valid   (o_seq_valid),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called 1 time unit after an edge with the DUT idle; returns at offset 1 (cycle N+1).
  task automatic handshake(input logic [3:0] pat, input logic [3:0] rep);
    i_start_valid = 1'b1;
    i_pattern     = pat;
    i_repeat_cnt  = rep;
    i_tx_en       = 1'b1;
    @(posedge clk); #1;
    i_start_valid = 1'b0;
    i_pattern     = 4'b0000;
    i_repeat_cnt  = 4'h0;
  endtask

  // Record the stream until one cycle past done; tx_en is low for offsets
  // [stall_at, stall_at+stall_len); start_valid is poked at offset poke_at.
  task automatic collect(input int stall_at, input int stall_len, input int poke_at,
                         input int budget);
    logic [3:0] det_sr;
    det_sr = '0;
    nbits = 0; done_off = -1; done_cnt = 0; det_cnt = 0; obs = '0; ready_after = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      i_tx_en       = !(k >= stall_at && k < stall_at + stall_len);
      i_start_valid = (k == poke_at);
      i_repeat_cnt  = (k == poke_at) ? 4'hF : 4'h0;
      if (done_off >= 0) begin
        ready_after = o_start_ready;
        if (o_done) done_cnt++;
        break;
      end
      tr_out[k]   = o_seq_out;
      tr_valid[k] = o_seq_valid;
      if (o_seq_valid && i_tx_en) begin
        bits[nbits] = o_seq_out;
        nbits++;
        obs    = {obs[62:0], o_seq_out};
        det_sr = {det_sr[2:0], o_seq_out};
        if (det_sr == 4'b1011) det_cnt++;
      end
      if (o_done) begin
        done_off = k;
        done_cnt++;
      end
      @(posedge clk); #1;
    end
    i_start_valid = 1'b0;
    i_repeat_cnt  = 4'h0;
    i_tx_en       = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (o_start_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready: got %b expected 1", o_start_ready);
    end
    tests_run++;
    if ({o_busy, o_seq_valid, o_seq_out, o_done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy/valid/out/done got %b expected 0000",
               {o_busy, o_seq_valid, o_seq_out, o_done});
    end
    rstn = 1'b1;
  endtask

  task automatic test_single();
    handshake(DEFAULT_PATTERN, 4'h0);
    collect(0, 0, 0, 20);
    tests_run++;
    if ({tr_out[1], tr_out[2], tr_out[3], tr_out[4]} !== 4'b1011) begin
      tests_failed++;
      $display("FAIL single_bits: got %b expected 1011",
               {tr_out[1], tr_out[2], tr_out[3], tr_out[4]});
    end
    tests_run++;
    if ({tr_valid[1], tr_valid[2], tr_valid[3], tr_valid[4]} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL single_valid: got %b expected 1111",
               {tr_valid[1], tr_valid[2], tr_valid[3], tr_valid[4]});
    end
    tests_run++;
    if (obs !== EXP_1011) begin
      tests_failed++; $display("FAIL single_stream: got %0h expected %0h", obs, EXP_1011);
    end
    tests_run++;
    if (done_off !== L + 1) begin
      tests_failed++; $display("FAIL single_done_cycle: got %0d expected %0d", done_off, L + 1);
    end
    tests_run++;
    if (ready_after !== 1'b1 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL single_ready_after: ready %b done_cnt %0d expected 1 and 1",
               ready_after, done_cnt);
    end
  endtask

  task automatic test_loopback();
    handshake(4'b1011, 4'h2);
    collect(0, 0, 0, 40);
    tests_run++;
    if (obs !== EXP_LOOP || nbits !== 3 * L) begin
      tests_failed++;
      $display("FAIL loop_stream: got %0h (%0d bits) expected %0h (%0d bits)",
               obs, nbits, EXP_LOOP, 3 * L);
    end
    tests_run++;
    if (det_cnt !== 3) begin
      tests_failed++; $display("FAIL loop_detect: got %0d expected 3", det_cnt);
    end
    tests_run++;
    if (done_off !== 3 * L + 1 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL loop_done: at %0d count %0d expected %0d count 1",
               done_off, done_cnt, 3 * L + 1);
    end
  endtask

  task automatic test_stall();
    handshake(4'b1011, 4'h0);
    collect(3, 3, 0, 30);
    tests_run++;
    if ({tr_out[2], tr_out[3], tr_out[4], tr_out[5], tr_out[6], tr_out[7]} !== 6'b011111) begin
      tests_failed++;
      $display("FAIL stall_hold: got %b expected 011111",
               {tr_out[2], tr_out[3], tr_out[4], tr_out[5], tr_out[6], tr_out[7]});
    end
    tests_run++;
    if ({tr_valid[3], tr_valid[4], tr_valid[5], tr_valid[6]} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL stall_valid: got %b expected 1111",
               {tr_valid[3], tr_valid[4], tr_valid[5], tr_valid[6]});
    end
    tests_run++;
    if (obs !== EXP_1011) begin
      tests_failed++; $display("FAIL stall_stream: got %0h expected %0h", obs, EXP_1011);
    end
    tests_run++;
    if (done_off !== L + 4) begin
      tests_failed++; $display("FAIL stall_done: got %0d expected %0d", done_off, L + 4);
    end
  endtask

  task automatic test_ignore_start();
    handshake(4'b1011, 4'h0);
    collect(0, 0, 2, 20);
    tests_run++;
    if (obs !== EXP_1011 || nbits !== L) begin
      tests_failed++;
      $display("FAIL ignore_stream: got %0h (%0d bits) expected %0h (%0d bits)",
               obs, nbits, EXP_1011, L);
    end
    tests_run++;
    if (done_off !== L + 1 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL ignore_done: at %0d count %0d expected %0d count 1",
               done_off, done_cnt, L + 1);
    end
  endtask

  task automatic test_midstream_reset();
    int stray_done;
    handshake(4'b1011, 4'h3);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    tests_run++;
    if ({o_seq_valid, o_busy, o_start_ready, o_done, o_seq_out} !== 5'b00100) begin
      tests_failed++;
      $display("FAIL midreset_outputs: valid/busy/ready/done/out got %b expected 00100",
               {o_seq_valid, o_busy, o_start_ready, o_done, o_seq_out});
    end
    stray_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_done || o_seq_valid) stray_done++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (stray_done !== 0) begin
      tests_failed++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", stray_done);
    end
    handshake(4'b1100, 4'h0);
    collect(0, 0, 0, 20);
    tests_run++;
    if (obs !== EXP_1100 || done_off !== L + 1) begin
      tests_failed++;
      $display("FAIL midreset_restart: got %0h done %0d expected %0h done %0d",
               obs, done_off, EXP_1100, L + 1);
    end
  endtask

  task automatic test_max_repeat();
    logic [3:0] pat;
    int         errs;
    logic       exp_bit;
    pat = 4'b0110;
    handshake(pat, 4'hF);
    collect(0, 0, 0, 200);
    errs = 0;
    for (int i = 0; i < nbits; i++) begin
      exp_bit = ((i % L) < 4) ? pat[3 - (i % L)] : 1'b0;
      if (bits[i] !== exp_bit) errs++;
    end
    tests_run++;
    if (nbits !== 16 * L || errs !== 0) begin
      tests_failed++;
      $display("FAIL maxrep_stream: got %0d bits %0d wrong expected %0d bits 0 wrong",
               nbits, errs, 16 * L);
    end
    tests_run++;
    if (done_off !== 16 * L + 1) begin
      tests_failed++; $display("FAIL maxrep_done: got %0d expected %0d", done_off, 16 * L + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_loopback();
    test_stall();
    test_ignore_start();
    test_midstream_reset();
    test_max_repeat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
